// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, field widths and the
// address-byte helper used by the target (and by the controller).
package i2c_pkg;

   localparam int unsigned ADDR_W    = 7;
   localparam int unsigned BIT_CNT_W = 4;
   localparam int unsigned BYTE_W    = 8;
   // Position of the R/W flag inside the address byte (LSB on the wire).
   localparam int unsigned RW_BIT    = 0;

   localparam logic [BIT_CNT_W-1:0] BITS_PER_BYTE = 4'd8;
   localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = 4'd7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_state_e;

   // True when the upper seven bits of a received address byte name us.
   function automatic logic addr_match(input logic [BYTE_W-1:0] addr_byte,
                                       input logic [ADDR_W-1:0] own_addr);
      return addr_byte[BYTE_W-1:1] == own_addr;
   endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Pad-side and fabric-side signals of the I2C target, grouped so the
// target sees the slave view and a driver/bench sees the master view.
interface i2c_target_if;
   import i2c_pkg::*;

   logic              scl_i;
   logic              sda_i;
   logic              sda_oe;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_req;
   logic              busy;
   logic              addressed;

   modport slave (
      input  scl_i, sda_i, tx_data,
      output sda_oe, rx_data, rx_valid, tx_req, busy, addressed
   );

   modport master (
      output scl_i, sda_i, tx_data,
      input  sda_oe, rx_data, rx_valid, tx_req, busy, addressed
   );

endinterface

// File: rtl/i2c_line_sync.sv
// Brings raw SCL/SDA into the clk domain and derives SCL edges and
// START/STOP conditions from the synchronized levels.
module i2c_line_sync (
   input  logic clk,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_s
);

   logic [1:0] scl_sync_q;
   logic [1:0] sda_sync_q;
   logic       scl_hist_q;
   logic       sda_hist_q;

   // Two-flop synchronizers plus one history flop per line. Left without
   // reset so a reset never fabricates edges or START/STOP on a live bus.
   always_ff @(posedge clk) begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
   end

   assign scl_rise = scl_sync_q[1] & ~scl_hist_q;
   assign scl_fall = ~scl_sync_q[1] & scl_hist_q;
   assign start    = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
   assign stop     = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];
   assign sda_s    = sda_sync_q[1];

endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write bytes out to fabric, read bytes
// from fabric onto an open-drain SDA. SCL is never stretched.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR = 7'h42
) (
   input logic        clk,
   input logic        rst,
   i2c_target_if.slave bus
);

   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;
   logic sda_s;

   i2c_line_sync u_line_sync (
      .clk      (clk),
      .scl_i    (bus.scl_i),
      .sda_i    (bus.sda_i),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_s    (sda_s)
   );

   i2c_state_e            state_q;
   logic [BIT_CNT_W-1:0]  bit_cnt_q;
   logic [BYTE_W-1:0]     shift_q;
   logic [BYTE_W-2:0]     tx_shift_q;
   logic                  sda_oe_q;
   logic [BYTE_W-1:0]     rx_data_q;
   logic                  rx_valid_q;
   logic                  tx_req_q;
   logic                  busy_q;
   logic                  addressed_q;

   // Bus protocol FSM; STOP/START take priority over bit handling, and
   // every SDA change is registered off a detected SCL fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_shift_q  <= '0;
         sda_oe_q    <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         addressed_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         if (stop) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
         end else if (start) begin
            state_q     <= ST_ADDR;
            bit_cnt_q   <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b1;
            addressed_q <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  sda_oe_q <= 1'b0;
               end

               ST_ADDR: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[BYTE_W-2:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                     bit_cnt_q <= '0;
                     if (addr_match(shift_q, ADDR)) begin
                        state_q     <= ST_ADDR_ACK;
                        sda_oe_q    <= 1'b1;
                        addressed_q <= 1'b1;
                     end else begin
                        state_q <= ST_IGNORE;
                     end
                  end
               end

               ST_ADDR_ACK: begin
                  if (scl_fall) begin
                     bit_cnt_q <= '0;
                     if (shift_q[RW_BIT]) begin
                        // First read bit goes out together with the tx_req pulse.
                        state_q    <= ST_RD_DATA;
                        tx_req_q   <= 1'b1;
                        tx_shift_q <= bus.tx_data[BYTE_W-2:0];
                        sda_oe_q   <= ~bus.tx_data[BYTE_W-1];
                     end else begin
                        state_q  <= ST_WR_DATA;
                        sda_oe_q <= 1'b0;
                     end
                  end
               end

               ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift_q   <= {shift_q[BYTE_W-2:0], sda_s};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == LAST_DATA_BIT) begin
                        rx_data_q  <= {shift_q[BYTE_W-2:0], sda_s};
                        rx_valid_q <= 1'b1;
                     end
                  end else if (scl_fall && bit_cnt_q == BITS_PER_BYTE) begin
                     state_q  <= ST_WR_ACK;
                     sda_oe_q <= 1'b1;
                  end
               end

               ST_WR_ACK: begin
                  if (scl_fall) begin
                     state_q   <= ST_WR_DATA;
                     bit_cnt_q <= '0;
                     sda_oe_q  <= 1'b0;
                  end
               end

               ST_RD_DATA: begin
                  if (scl_rise) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (scl_fall) begin
                     if (bit_cnt_q == BITS_PER_BYTE) begin
                        state_q  <= ST_RD_ACK;
                        sda_oe_q <= 1'b0;
                     end else begin
                        sda_oe_q   <= ~tx_shift_q[BYTE_W-2];
                        tx_shift_q <= {tx_shift_q[BYTE_W-3:0], 1'b0};
                     end
                  end
               end

               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state_q     <= ST_IGNORE;
                        addressed_q <= 1'b0;
                     end
                  end else if (scl_fall) begin
                     state_q    <= ST_RD_DATA;
                     bit_cnt_q  <= '0;
                     tx_req_q   <= 1'b1;
                     tx_shift_q <= bus.tx_data[BYTE_W-2:0];
                     sda_oe_q   <= ~bus.tx_data[BYTE_W-1];
                  end
               end

               ST_IGNORE: begin
                  sda_oe_q <= 1'b0;
               end

               default: begin
                  state_q  <= ST_IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sda_oe    = sda_oe_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.tx_req    = tx_req_q;
   assign bus.busy      = busy_q;
   assign bus.addressed = addressed_q;

endmodule
